// File: rtl/cpu_exec_units.sv
// cpu_exec_units: small CPU datapath slice.
//   - combinational 8-bit ALU with carry/borrow out and an A-is-zero flag
//   - 8-bit loadable up/down counter
//   - 4-bit micro-cycle counter plus a combinational (opcode, cycle) state decoder
// All state is cleared asynchronously by the active-low reset input.
module cpu_exec_units (
    input  logic       clk,
    input  logic       reset,
    // ALU
    input  logic [7:0] alu_a,
    input  logic [7:0] alu_b,
    input  logic       alu_cin,
    input  logic [2:0] alu_mode,
    output logic [7:0] alu_out,
    output logic       alu_cout,
    output logic       alu_eq_zero,
    // counter
    input  logic       cnt_en,
    input  logic       cnt_load,
    input  logic       cnt_down,
    input  logic [7:0] cnt_in,
    output logic [7:0] cnt_out,
    // control sequencer
    input  logic [7:0] opcode,
    input  logic       reset_cycle,
    output logic [3:0] cycle,
    output logic [7:0] state
);

    typedef enum logic [4:0] {
        ST_FETCH_PC   = 5'd0,
        ST_FETCH_INST = 5'd1,
        ST_ALU_OP     = 5'd2,
        ST_MOV_FETCH  = 5'd3,
        ST_MOV_LOAD   = 5'd4,
        ST_MOV_STORE  = 5'd5,
        ST_LDI        = 5'd6,
        ST_JUMP       = 5'd7,
        ST_TMP_STORE  = 5'd8,
        ST_FETCH_SP   = 5'd9,
        ST_PC_STORE   = 5'd10,
        ST_TMP_JUMP   = 5'd11,
        ST_INC_SP     = 5'd12,
        ST_RET        = 5'd13,
        ST_OUT_A      = 5'd14,
        ST_HALT       = 5'd15,
        ST_NEXT       = 5'd16
    } state_e;

    logic [7:0] r_cnt;
    logic [3:0] r_cycle;
    logic [8:0] w_alu_res;
    logic [7:0] w_and;
    logic [7:0] w_or;
    logic [7:0] w_xor;
    logic [7:0] w_not;
    logic [3:0] w_step;
    state_e     w_state;

    // Per-bit logic operations for the ALU logic modes
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi = gi + 1) begin : g_logic_bit
            assign w_and[gi] = alu_a[gi] & alu_b[gi];
            assign w_or[gi]  = alu_a[gi] | alu_b[gi];
            assign w_xor[gi] = alu_a[gi] ^ alu_b[gi];
            assign w_not[gi] = ~alu_a[gi];
        end
    endgenerate

    // ALU: 9-bit arithmetic so bit 8 is carry (add/inc) or borrow (sub/dec)
    always_comb begin
        w_alu_res = 9'd0;
        case (alu_mode)
            3'd0:    w_alu_res = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
            3'd1:    w_alu_res = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
            3'd2:    w_alu_res = {1'b0, alu_a} + 9'd1;
            3'd3:    w_alu_res = {1'b0, alu_a} - 9'd1;
            3'd4:    w_alu_res = {1'b0, w_and};
            3'd5:    w_alu_res = {1'b0, w_or};
            3'd6:    w_alu_res = {1'b0, w_xor};
            default: w_alu_res = {1'b0, w_not};
        endcase
    end

    assign alu_out     = w_alu_res[7:0];
    assign alu_cout    = w_alu_res[8];
    assign alu_eq_zero = (alu_a == 8'h00);

    // Counter: enable gates everything, load wins over counting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 8'h00;
        end else if (cnt_en) begin
            if (cnt_load) begin
                r_cnt <= cnt_in;
            end else if (cnt_down) begin
                r_cnt <= r_cnt - 8'd1;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign cnt_out = r_cnt;

    // Micro-cycle counter: free-running 0..15, restarted by reset_cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle <= 4'd0;
        end else if (reset_cycle) begin
            r_cycle <= 4'd0;
        end else begin
            r_cycle <= r_cycle + 4'd1;
        end
    end

    assign cycle  = r_cycle;
    assign w_step = r_cycle - 4'd2;

    // State decode: common two-cycle fetch, then per-opcode sequence; past the
    // end of a sequence (or for unknown opcodes) the decoder sits in NEXT
    always_comb begin
        w_state = ST_NEXT;
        if (r_cycle == 4'd0) begin
            w_state = ST_FETCH_PC;
        end else if (r_cycle == 4'd1) begin
            w_state = ST_FETCH_INST;
        end else begin
            casez (opcode)
                8'b00???000: begin
                    if (w_step == 4'd0) w_state = ST_ALU_OP;
                end
                8'b01??????: begin
                    case (w_step)
                        4'd0:    w_state = ST_MOV_FETCH;
                        4'd1:    w_state = ST_MOV_LOAD;
                        4'd2:    w_state = ST_MOV_STORE;
                        default: w_state = ST_NEXT;
                    endcase
                end
                8'b10000???: begin
                    case (w_step)
                        4'd0:    w_state = ST_FETCH_PC;
                        4'd1:    w_state = ST_LDI;
                        default: w_state = ST_NEXT;
                    endcase
                end
                8'hC0, 8'hC1, 8'hC2: begin
                    case (w_step)
                        4'd0:    w_state = ST_FETCH_PC;
                        4'd1:    w_state = ST_JUMP;
                        default: w_state = ST_NEXT;
                    endcase
                end
                8'hC3: begin
                    case (w_step)
                        4'd0:    w_state = ST_FETCH_PC;
                        4'd1:    w_state = ST_TMP_STORE;
                        4'd2:    w_state = ST_FETCH_SP;
                        4'd3:    w_state = ST_PC_STORE;
                        4'd4:    w_state = ST_TMP_JUMP;
                        default: w_state = ST_NEXT;
                    endcase
                end
                8'hC4: begin
                    case (w_step)
                        4'd0:    w_state = ST_INC_SP;
                        4'd1:    w_state = ST_FETCH_SP;
                        4'd2:    w_state = ST_RET;
                        default: w_state = ST_NEXT;
                    endcase
                end
                8'hC5: begin
                    if (w_step == 4'd0) w_state = ST_OUT_A;
                end
                8'hC6: begin
                    w_state = ST_HALT;
                end
                default: begin
                    w_state = ST_NEXT;
                end
            endcase
        end
    end

    assign state = {3'b000, w_state};

endmodule

// File: tb/tb_cpu_exec_units.sv
// Directed testbench for cpu_exec_units: one task per feature, inline checks.
module tb_cpu_exec_units;

    logic       clk;
    logic       reset;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_cin;
    logic [2:0] alu_mode;
    logic [7:0] alu_out;
    logic       alu_cout;
    logic       alu_eq_zero;
    logic       cnt_en;
    logic       cnt_load;
    logic       cnt_down;
    logic [7:0] cnt_in;
    logic [7:0] cnt_out;
    logic [7:0] opcode;
    logic       reset_cycle;
    logic       reset_cycle_drv;
    logic       tie_en;
    logic [3:0] cycle;
    logic [7:0] state;

    int checks;
    int failures;

    assign reset_cycle = tie_en ? (state == 8'd16) : reset_cycle_drv;

    cpu_exec_units dut (
        .clk         (clk),
        .reset       (reset),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_cin     (alu_cin),
        .alu_mode    (alu_mode),
        .alu_out     (alu_out),
        .alu_cout    (alu_cout),
        .alu_eq_zero (alu_eq_zero),
        .cnt_en      (cnt_en),
        .cnt_load    (cnt_load),
        .cnt_down    (cnt_down),
        .cnt_in      (cnt_in),
        .cnt_out     (cnt_out),
        .opcode      (opcode),
        .reset_cycle (reset_cycle),
        .cycle       (cycle),
        .state       (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Restart the micro-cycle counter so cycle reads 0
    task automatic sync_cycle();
        reset_cycle_drv = 1'b1;
        tick();
        reset_cycle_drv = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (cnt_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_cnt got=%h exp=00", cnt_out);
        end
        checks++;
        if (cycle !== 4'd0) begin
            failures++;
            $display("FAIL reset_cycle got=%0d exp=0", cycle);
        end
        checks++;
        if (state !== 8'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=0", state);
        end
        $display("reset: cnt=%h cycle=%0d state=%0d", cnt_out, cycle, state);
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct packed {
        logic [2:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] out;
        logic       cout;
        logic       z;
    } alu_vec_t;

    task automatic test_alu();
        alu_vec_t v[14];
        v[0]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        v[1]  = '{3'd0, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0};
        v[2]  = '{3'd1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0};
        v[3]  = '{3'd1, 8'h07, 8'h05, 1'b1, 8'h01, 1'b0, 1'b0};
        v[4]  = '{3'd2, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
        v[5]  = '{3'd2, 8'h41, 8'h99, 1'b1, 8'h42, 1'b0, 1'b0};
        v[6]  = '{3'd3, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b1};
        v[7]  = '{3'd3, 8'h10, 8'h55, 1'b0, 8'h0F, 1'b0, 1'b0};
        v[8]  = '{3'd4, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0};
        v[9]  = '{3'd5, 8'hF0, 8'h0C, 1'b0, 8'hFC, 1'b0, 1'b0};
        v[10] = '{3'd6, 8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0};
        v[11] = '{3'd7, 8'h5A, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0};
        v[12] = '{3'd4, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1};
        v[13] = '{3'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
        for (int i = 0; i < 14; i++) begin
            alu_mode = v[i].mode;
            alu_a    = v[i].a;
            alu_b    = v[i].b;
            alu_cin  = v[i].cin;
            #1;
            checks++;
            if ({alu_out, alu_cout, alu_eq_zero} !== {v[i].out, v[i].cout, v[i].z}) begin
                failures++;
                $display("FAIL alu_%0d mode=%0d a=%h b=%h cin=%b got out=%h cout=%b z=%b exp out=%h cout=%b z=%b",
                         i, v[i].mode, v[i].a, v[i].b, v[i].cin, alu_out, alu_cout, alu_eq_zero,
                         v[i].out, v[i].cout, v[i].z);
            end
            $display("alu: mode=%0d a=%h b=%h cin=%b -> out=%h cout=%b z=%b",
                     alu_mode, alu_a, alu_b, alu_cin, alu_out, alu_cout, alu_eq_zero);
        end
    endtask

    task automatic test_counter();
        // en, load, down, in, expected value after the edge
        logic [7:0] exp_v[10];
        logic [2:0] ctl[10];
        logic [7:0] din[10];
        ctl[0] = 3'b110; din[0] = 8'h10; exp_v[0] = 8'h10;
        ctl[1] = 3'b100; din[1] = 8'h00; exp_v[1] = 8'h11;
        ctl[2] = 3'b100; din[2] = 8'h00; exp_v[2] = 8'h12;
        ctl[3] = 3'b100; din[3] = 8'h00; exp_v[3] = 8'h13;
        ctl[4] = 3'b111; din[4] = 8'h00; exp_v[4] = 8'h00;
        ctl[5] = 3'b101; din[5] = 8'h77; exp_v[5] = 8'hFF;
        ctl[6] = 3'b000; din[6] = 8'h00; exp_v[6] = 8'hFF;
        ctl[7] = 3'b011; din[7] = 8'h55; exp_v[7] = 8'hFF;
        ctl[8] = 3'b100; din[8] = 8'h00; exp_v[8] = 8'h00;
        ctl[9] = 3'b101; din[9] = 8'h00; exp_v[9] = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            {cnt_en, cnt_load, cnt_down} = ctl[i];
            cnt_in = din[i];
            tick();
            checks++;
            if (cnt_out !== exp_v[i]) begin
                failures++;
                $display("FAIL cnt_%0d en=%b load=%b down=%b got=%h exp=%h",
                         i, cnt_en, cnt_load, cnt_down, cnt_out, exp_v[i]);
            end
            $display("cnt: en=%b load=%b down=%b in=%h -> out=%h",
                     cnt_en, cnt_load, cnt_down, cnt_in, cnt_out);
        end
        cnt_en   = 1'b0;
        cnt_load = 1'b0;
        cnt_down = 1'b0;
    endtask

    task automatic test_decode();
        // byte i of each row = expected state at cycle i
        logic [7:0]  ops[14];
        logic [63:0] rows[14];
        logic [63:0] row;
        logic [7:0]  exp_s;
        ops[0]  = 8'hC3; rows[0]  = 64'h100B0A0908000100;
        ops[1]  = 8'h28; rows[1]  = 64'h1010101010020100;
        ops[2]  = 8'h7A; rows[2]  = 64'h1010100504030100;
        ops[3]  = 8'h83; rows[3]  = 64'h1010101006000100;
        ops[4]  = 8'hC0; rows[4]  = 64'h1010101007000100;
        ops[5]  = 8'hC1; rows[5]  = 64'h1010101007000100;
        ops[6]  = 8'hC2; rows[6]  = 64'h1010101007000100;
        ops[7]  = 8'hC4; rows[7]  = 64'h1010100D090C0100;
        ops[8]  = 8'hC5; rows[8]  = 64'h10101010100E0100;
        ops[9]  = 8'hC7; rows[9]  = 64'h1010101010100100;
        ops[10] = 8'hC6; rows[10] = 64'h0F0F0F0F0F0F0100;
        ops[11] = 8'h3F; rows[11] = 64'h1010101010100100;
        ops[12] = 8'h88; rows[12] = 64'h1010101010100100;
        ops[13] = 8'hC8; rows[13] = 64'h1010101010100100;
        for (int k = 0; k < 14; k++) begin
            opcode = ops[k];
            sync_cycle();
            row = rows[k];
            for (int c = 0; c < 17; c++) begin
                if (c < 8)        exp_s = row[8*c +: 8];
                else if (c == 16) exp_s = 8'd0;
                else              exp_s = (ops[k] == 8'hC6) ? 8'd15 : 8'd16;
                checks++;
                if (cycle !== 4'(c) || state !== exp_s) begin
                    failures++;
                    $display("FAIL decode op=%h step=%0d got cycle=%0d state=%0d exp cycle=%0d state=%0d",
                             opcode, c, cycle, state, c % 16, exp_s);
                end
                if (c < 8)
                    $display("decode: op=%h cycle=%0d state=%0d", opcode, cycle, state);
                tick();
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_c[7];
        logic [7:0] exp_s[7];
        exp_c = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
        exp_s = '{8'd0, 8'd1, 8'd3, 8'd4, 8'd5, 8'd16, 8'd0};
        opcode = 8'b0111_1000;
        sync_cycle();
        tie_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (cycle !== exp_c[i] || state !== exp_s[i]) begin
                failures++;
                $display("FAIL mov_tie step=%0d got cycle=%0d state=%0d exp cycle=%0d state=%0d",
                         i, cycle, state, exp_c[i], exp_s[i]);
            end
            $display("mov_tie: cycle=%0d state=%0d rc=%b", cycle, state, reset_cycle);
            tick();
        end
        tie_en = 1'b0;
    endtask

    task automatic test_async_reset();
        opcode   = 8'hC3;
        cnt_en   = 1'b1;
        cnt_load = 1'b1;
        cnt_in   = 8'h42;
        sync_cycle();
        cnt_en   = 1'b0;
        cnt_load = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (cycle !== 4'd4 || cnt_out !== 8'h42 || state !== 8'd9) begin
            failures++;
            $display("FAIL pre_reset got cycle=%0d cnt=%h state=%0d exp cycle=4 cnt=42 state=9",
                     cycle, cnt_out, state);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (cycle !== 4'd0 || cnt_out !== 8'h00 || state !== 8'd0) begin
            failures++;
            $display("FAIL async_reset got cycle=%0d cnt=%h state=%0d exp cycle=0 cnt=00 state=0",
                     cycle, cnt_out, state);
        end
        $display("async_reset: cycle=%0d cnt=%h state=%0d", cycle, cnt_out, state);
        // Held in reset across an edge with the counter enabled
        cnt_en = 1'b1;
        tick();
        checks++;
        if (cycle !== 4'd0 || cnt_out !== 8'h00) begin
            failures++;
            $display("FAIL held_reset got cycle=%0d cnt=%h exp cycle=0 cnt=00", cycle, cnt_out);
        end
        cnt_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++;
        if (cycle !== 4'd1 || state !== 8'd1 || cnt_out !== 8'h00) begin
            failures++;
            $display("FAIL resume got cycle=%0d state=%0d cnt=%h exp cycle=1 state=1 cnt=00",
                     cycle, state, cnt_out);
        end
        $display("resume: cycle=%0d state=%0d cnt=%h", cycle, state, cnt_out);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b0;
        alu_a           = 8'h00;
        alu_b           = 8'h00;
        alu_cin         = 1'b0;
        alu_mode        = 3'd0;
        cnt_en          = 1'b0;
        cnt_load        = 1'b0;
        cnt_down        = 1'b0;
        cnt_in          = 8'h00;
        opcode          = 8'hC7;
        reset_cycle_drv = 1'b0;
        tie_en          = 1'b0;

        test_reset();
        test_alu();
        test_counter();
        test_decode();
        test_back_to_back();
        test_async_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
